// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-to-1 cached-bus arbiter (fixed priority or round-robin), grant held per burst.
// Define CBUS_ARB_XLAT_EN to add the address-translation and page-walk stage ahead of the transfer.

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned NUM_INPUTS    = 2,
    parameter int unsigned PRIORITY_MODE = 1,
    localparam int unsigned IDX_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        xlat_req_valid,
    output logic [63:0]                 xlat_vaddr,
    input  logic                        xlat_resp_valid,
    input  logic [63:0]                 xlat_paddr,
    input  logic                        xlat_fault,
    input  cbus_req_t                   walk_req,
    output cbus_resp_t                  walk_resp,
    output logic                        fault_pulse
);

    typedef enum logic [2:0] {StIdle, StXlat, StWalk, StXfer, StFault} state_e;

    state_e           state_q, state_d;
    logic             grant_valid_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [IDX_W-1:0] rr_ptr_q;

    logic [IDX_W-1:0] scan_start;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [IDX_W-1:0] ptr_next;
    logic             burst_done;

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

    // Fixed priority always scans from port 0; round-robin starts one past the last grantee.
    assign scan_start = (PRIORITY_MODE == 1) ? rr_ptr_q : '0;

    always_comb begin
        int unsigned cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            cand = (32'(scan_start) + k) % NUM_INPUTS;
            if (!sel_found && ireqs[IDX_W'(cand)].valid) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    assign ptr_next   = (grant_idx_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx_q + 1'b1;
    assign burst_done = ((state_q == StXfer) && oresp.last) || (state_q == StFault);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && sel_found) begin
                grant_valid_q <= 1'b1;
                grant_idx_q   <= sel_idx;
            end else if (burst_done) begin
                grant_valid_q <= 1'b0;
                rr_ptr_q      <= ptr_next;
            end
        end
    end

`ifdef CBUS_ARB_XLAT_EN
    logic [63:0] paddr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            paddr_q <= '0;
        end else if ((state_q == StXlat) && xlat_resp_valid && !xlat_fault) begin
            paddr_q <= xlat_paddr;
        end
    end
`else
    logic unused_xlat;
    assign unused_xlat = ^{xlat_resp_valid, xlat_paddr, xlat_fault, walk_req};
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
`ifdef CBUS_ARB_XLAT_EN
                    state_d = StXlat;
`else
                    state_d = StXfer;
`endif
                end
            end
            StXfer: begin
                if (oresp.last) state_d = StIdle;
            end
`ifdef CBUS_ARB_XLAT_EN
            StXlat: begin
                // A translation result takes precedence over a simultaneous walk request.
                if (xlat_resp_valid) begin
                    state_d = xlat_fault ? StFault : StXfer;
                end else if (walk_req.valid) begin
                    state_d = StWalk;
                end
            end
            StWalk: begin
                if (oresp.last) state_d = StXlat;
            end
            StFault: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        oreq           = '0;
        iresps         = '0;
        walk_resp      = '0;
        xlat_req_valid = 1'b0;
        xlat_vaddr     = '0;
        fault_pulse    = 1'b0;
        unique case (state_q)
            StXfer: begin
                oreq = ireqs[grant_idx_q];
`ifdef CBUS_ARB_XLAT_EN
                oreq.addr = paddr_q;
`endif
                iresps[grant_idx_q] = oresp;
            end
`ifdef CBUS_ARB_XLAT_EN
            StXlat: begin
                xlat_req_valid = 1'b1;
                xlat_vaddr     = ireqs[grant_idx_q].addr;
            end
            StWalk: begin
                oreq      = walk_req;
                walk_resp = oresp;
            end
            StFault: begin
                iresps[grant_idx_q] = '{ready: 1'b1, last: 1'b1, data: '0};
                fault_pulse         = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: random traffic on a 2-port fixed-priority and a 4-port round-robin arbiter,
// checked against a burst-level model; directed translation scenarios when CBUS_ARB_XLAT_EN is set.
`timescale 1ns/1ps
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int NA   = 2;
    localparam int NB   = 4;
    localparam int NMAX = 4;
    localparam int NCYC = 6000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_req_t  [NA-1:0] ireqs_a;
    cbus_resp_t [NA-1:0] iresps_a;
    cbus_req_t           oreq_a, walk_req_a;
    cbus_resp_t          oresp_a, walk_resp_a;
    logic                gv_a, xrv_a, xrsp_a, xflt_a, fp_a;
    logic [0:0]          gi_a;
    logic [63:0]         xva_a, xpa_a;

    cbus_req_t  [NB-1:0] ireqs_b;
    cbus_resp_t [NB-1:0] iresps_b;
    cbus_req_t           oreq_b, walk_req_b;
    cbus_resp_t          oresp_b, walk_resp_b;
    logic                gv_b, xrv_b, xrsp_b, xflt_b, fp_b;
    logic [1:0]          gi_b;
    logic [63:0]         xva_b, xpa_b;

    cbus_rr_arbiter #(.NUM_INPUTS(NA), .PRIORITY_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .ireqs(ireqs_a), .iresps(iresps_a), .oreq(oreq_a),
        .oresp(oresp_a), .grant_valid(gv_a), .grant_idx(gi_a), .xlat_req_valid(xrv_a),
        .xlat_vaddr(xva_a), .xlat_resp_valid(xrsp_a), .xlat_paddr(xpa_a), .xlat_fault(xflt_a),
        .walk_req(walk_req_a), .walk_resp(walk_resp_a), .fault_pulse(fp_a)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(NB), .PRIORITY_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .ireqs(ireqs_b), .iresps(iresps_b), .oreq(oreq_b),
        .oresp(oresp_b), .grant_valid(gv_b), .grant_idx(gi_b), .xlat_req_valid(xrv_b),
        .xlat_vaddr(xva_b), .xlat_resp_valid(xrsp_b), .xlat_paddr(xpa_b), .xlat_fault(xflt_b),
        .walk_req(walk_req_b), .walk_resp(walk_resp_b), .fault_pulse(fp_b)
    );

    // Reference model: per instance, which requester owns the bus and where round-robin resumes.
    cbus_req_t  rq    [2][NMAX];
    cbus_resp_t mresp [2];
    int         busy  [2];
    int         owner [2];
    int         ptr   [2];
    int         beat  [2];
    int         n_of    [2] = '{NA, NB};
    int         mode_of [2] = '{0, 1};
    int         checks = 0;
    int         errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cbus_req_t new_req();
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom_range(1));
        r.addr     = {$urandom, $urandom};
        r.data     = {$urandom, $urandom};
        r.len      = 8'($urandom_range(4, 1));
        return r;
    endfunction

    function automatic int pick(input int k);
        int start;
        int i;
        start = (mode_of[k] == 1) ? ptr[k] : 0;
        for (int j = 0; j < n_of[k]; j++) begin
            i = (start + j) % n_of[k];
            if (rq[k][i].valid) return i;
        end
        return -1;
    endfunction

    function automatic cbus_resp_t gen_resp(input int k);
        cbus_resp_t r;
        r.data = {$urandom, $urandom};
        if (busy[k] != 0) begin
            r.ready = ($urandom_range(3) != 0);
            r.last  = r.ready && (beat[k] == int'(rq[k][owner[k]].len) - 1);
        end else begin
            r.ready = 1'($urandom_range(1));
            r.last  = 1'($urandom_range(1));
        end
        return r;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < 2; k++) mresp[k] = gen_resp(k);
        for (int i = 0; i < NA; i++) ireqs_a[i] = rq[0][i];
        for (int i = 0; i < NB; i++) ireqs_b[i] = rq[1][i];
        oresp_a = mresp[0];
        oresp_b = mresp[1];
        // Translation-side inputs carry noise; without translation they must have no effect.
        walk_req_a       = new_req();
        walk_req_a.valid = 1'($urandom_range(1));
        walk_req_b       = new_req();
        walk_req_b.valid = 1'($urandom_range(1));
        xrsp_a = 1'($urandom_range(1));
        xrsp_b = 1'($urandom_range(1));
        xflt_a = 1'($urandom_range(1));
        xflt_b = 1'($urandom_range(1));
        xpa_a  = {$urandom, $urandom};
        xpa_b  = {$urandom, $urandom};
    endtask

    task automatic check_outputs(input int k);
        cbus_req_t    o, eo;
        cbus_resp_t   r [NMAX];
        cbus_resp_t   er;
        logic         gv;
        int           gi;
        logic [255:0] misc;
        string        p;
        if (k == 0) begin
            o = oreq_a; gv = gv_a; gi = int'(gi_a); p = "a";
            for (int i = 0; i < NA; i++) r[i] = iresps_a[i];
            misc = 256'({xrv_a, xva_a, walk_resp_a, fp_a});
        end else begin
            o = oreq_b; gv = gv_b; gi = int'(gi_b); p = "b";
            for (int i = 0; i < NB; i++) r[i] = iresps_b[i];
            misc = 256'({xrv_b, xva_b, walk_resp_b, fp_b});
        end
        eo = '0;
        if (busy[k] != 0) eo = rq[k][owner[k]];
        check_eq({p, ".grant_valid"}, 256'(gv), 256'(busy[k] != 0));
        check_eq({p, ".grant_idx"}, 256'(gi), 256'(owner[k]));
        check_eq({p, ".oreq"}, 256'(o), 256'(eo));
        for (int i = 0; i < n_of[k]; i++) begin
            er = '0;
            if (busy[k] != 0 && i == owner[k]) er = mresp[k];
            check_eq($sformatf("%s.iresp%0d", p, i), 256'(r[i]), 256'(er));
        end
        check_eq({p, ".xlat_tied"}, misc, 256'(0));
    endtask

    task automatic update_model(input int k);
        int w;
        if (reset) begin
            busy[k] = 0; owner[k] = 0; ptr[k] = 0; beat[k] = 0;
        end else if (busy[k] == 0) begin
            w = pick(k);
            if (w >= 0) begin
                busy[k] = 1; owner[k] = w; beat[k] = 0;
            end
        end else begin
            if (mresp[k].ready) beat[k]++;
            if (mresp[k].last) begin
                busy[k] = 0;
                ptr[k]  = (owner[k] + 1) % n_of[k];
                if ($urandom_range(1) == 0) rq[k][owner[k]].valid = 1'b0;
                else rq[k][owner[k]] = new_req();
            end
        end
        for (int i = 0; i < n_of[k]; i++) begin
            if (!rq[k][i].valid && $urandom_range(3) == 0) rq[k][i] = new_req();
        end
    endtask

`ifdef CBUS_ARB_XLAT_EN
    task automatic xlat_directed();
        cbus_resp_t mr;
        cbus_resp_t fr;
        reset = 1'b0;
        ireqs_b = '0; oresp_b = '0; walk_req_b = '0; xrsp_b = 1'b0; xflt_b = 1'b0; xpa_b = '0;
        ireqs_a = '0; oresp_a = '0; walk_req_a = '0; xrsp_a = 1'b0; xflt_a = 1'b0; xpa_a = '0;
        fr = '{ready: 1'b1, last: 1'b1, data: 64'h0};
        @(negedge clk);
        ireqs_a[0] = '{valid: 1'b1, is_write: 1'b0, addr: 64'h8000_1000, data: 64'h0, len: 8'd1};
        #1; check_eq("x.idle_gv", 256'(gv_a), 256'(0));
        @(negedge clk);
        walk_req_a = '{valid: 1'b1, is_write: 1'b0, addr: 64'h10_0000, data: 64'h0, len: 8'd1};
        #1; check_eq("x.req_valid", 256'(xrv_a), 256'(1));
        check_eq("x.vaddr", 256'(xva_a), 256'(64'h8000_1000));
        check_eq("x.oreq_quiet", 256'(oreq_a), 256'(0));
        @(negedge clk);
        mr = '{ready: 1'b1, last: 1'b1, data: 64'hAAAA}; oresp_a = mr;
        #1; check_eq("x.walk1_oreq", 256'(oreq_a), 256'(walk_req_a));
        check_eq("x.walk1_resp", 256'(walk_resp_a), 256'(mr));
        check_eq("x.walk1_iresp", 256'(iresps_a[0]), 256'(0));
        @(negedge clk);
        walk_req_a.addr = 64'h10_0008; oresp_a = '0;
        #1; check_eq("x.back_in_xlat", 256'(xrv_a), 256'(1));
        @(negedge clk);
        mr = '{ready: 1'b1, last: 1'b1, data: 64'hBBBB}; oresp_a = mr;
        #1; check_eq("x.walk2_addr", 256'(oreq_a.addr), 256'(64'h10_0008));
        check_eq("x.walk2_resp", 256'(walk_resp_a), 256'(mr));
        @(negedge clk);
        walk_req_a = '0; oresp_a = '0; xrsp_a = 1'b1; xpa_a = 64'h8020_1000;
        #1; check_eq("x.wait_resp", 256'(xrv_a), 256'(1));
        @(negedge clk);
        xrsp_a = 1'b0; mr = '{ready: 1'b1, last: 1'b1, data: 64'hCCCC}; oresp_a = mr;
        #1; check_eq("x.xfer_valid", 256'(oreq_a.valid), 256'(1));
        check_eq("x.xfer_paddr", 256'(oreq_a.addr), 256'(64'h8020_1000));
        check_eq("x.xfer_data", 256'(iresps_a[0]), 256'(mr));
        @(negedge clk);
        oresp_a = '0; ireqs_a[0].addr = 64'h8000_2000;
        #1; check_eq("x.done_gv", 256'(gv_a), 256'(0));
        @(negedge clk);
        xrsp_a = 1'b1; xflt_a = 1'b1;
        #1; check_eq("x.flt_vaddr", 256'(xva_a), 256'(64'h8000_2000));
        @(negedge clk);
        xrsp_a = 1'b0; xflt_a = 1'b0;
        #1; check_eq("x.flt_iresp", 256'(iresps_a[0]), 256'(fr));
        check_eq("x.flt_pulse", 256'(fp_a), 256'(1));
        check_eq("x.flt_no_oreq", 256'(oreq_a.valid), 256'(0));
        @(negedge clk);
        #1; check_eq("x.flt_pulse_end", 256'(fp_a), 256'(0));
        check_eq("x.flt_gv", 256'(gv_a), 256'(0));
        @(negedge clk);
        walk_req_a = '{valid: 1'b1, is_write: 1'b0, addr: 64'h10_0010, data: 64'h0, len: 8'd1};
        xrsp_a = 1'b1; xpa_a = 64'h8030_0000;
        #1; check_eq("x.race_xlat", 256'(xrv_a), 256'(1));
        @(negedge clk);
        xrsp_a = 1'b0; mr = '{ready: 1'b1, last: 1'b1, data: 64'hDDDD}; oresp_a = mr;
        #1; check_eq("x.race_paddr", 256'(oreq_a.addr), 256'(64'h8030_0000));
        check_eq("x.race_no_walk", 256'(walk_resp_a), 256'(0));
        check_eq("x.race_data", 256'(iresps_a[0]), 256'(mr));
        @(negedge clk);
        ireqs_a = '0; walk_req_a = '0; oresp_a = '0;
        #1; check_eq("x.final_gv", 256'(gv_a), 256'(0));
    endtask
`endif

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; owner[k] = 0; ptr[k] = 0; beat[k] = 0;
            for (int i = 0; i < NMAX; i++) rq[k][i] = '0;
        end
        drive_inputs();
        repeat (3) @(posedge clk);
`ifdef CBUS_ARB_XLAT_EN
        xlat_directed();
`else
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            reset = (c < 2) ? 1'b0 : ($urandom_range(149) == 0);
            drive_inputs();
            #1;
            check_outputs(0);
            check_outputs(1);
            update_model(0);
            update_model(1);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
